// File: rtl/fc_argmax_if.sv
// Score-vector input and argmax-result output channels of the classification stage.
// Both directions use a valid/ready handshake.
interface fc_argmax_if #(
    parameter int unsigned IN_WIDTH = 22,
    parameter int unsigned N_CLASS  = 10
);
    localparam int unsigned IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [IN_WIDTH*N_CLASS-1:0]  in_score;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             out_class;
    logic [IN_WIDTH-1:0]          out_score;

    modport master (
        output in_valid, in_score, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  in_valid, in_score, out_ready,
        output in_ready, out_valid, out_class, out_score
    );
endinterface

// File: rtl/fc_argmax.sv
// Final classification stage: latches all class scores in one transfer, scans them
// one compare per cycle and returns the index/value of the (lowest-index) maximum.
module fc_argmax #(
    parameter int unsigned IN_WIDTH = 22,
    parameter int unsigned N_CLASS  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    fc_argmax_if.slave    bus
);
    localparam int unsigned IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [IN_WIDTH-1:0]   score_q [N_CLASS];
    logic [IN_WIDTH-1:0]   score_d [N_CLASS];
    logic [IN_WIDTH-1:0]   best_q,      best_d;
    logic [IDX_W-1:0]      best_idx_q,  best_idx_d;
    logic [IDX_W-1:0]      cnt_q,       cnt_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      out_class_q, out_class_d;
    logic [IN_WIDTH-1:0]   out_score_q, out_score_d;
    logic [IN_WIDTH-1:0]   cand;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int k = 0; k < N_CLASS; k++) score_q[k] <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            state_q     <= state_d;
            for (int k = 0; k < N_CLASS; k++) score_q[k] <= score_d[k];
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
        end
    end

    // Next-state and registered-output logic; outputs are set on the DONE entry edge
    always_comb begin
        state_d     = state_q;
        for (int k = 0; k < N_CLASS; k++) score_d[k] = score_q[k];
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        cand        = score_q[cnt_q];

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int k = 0; k < N_CLASS; k++)
                        score_d[k] = bus.in_score[k*IN_WIDTH +: IN_WIDTH];
                    best_d     = score_d[0];
                    best_idx_d = '0;
                    cnt_d      = IDX_W'(1);
                    in_ready_d = 1'b0;
                    if (N_CLASS == 1) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_class_d = '0;
                        out_score_d = score_d[0];
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Strictly-greater replacement keeps the lowest index on ties
                if ($signed(cand) > $signed(best_q)) begin
                    best_d     = cand;
                    best_idx_d = cnt_q;
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(N_CLASS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_class_d = best_idx_d;
                    out_score_d = best_d;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
endmodule
